// File: rtl/data_access_sched.sv
// rtl/data_access_sched.sv - data store request scheduler with zero-fill sweep
// Arbitrates fills against core requests and registers the chosen op onto the store controls.
module data_access_sched #(
  parameter int LINES      = 64,
  parameter int ADDRW      = $clog2(LINES),
  parameter int FILLW      = 512,
  parameter int PAYLOADW   = 64,
  parameter int TAGW       = 8,
  parameter int FAIR_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fill_valid,
  output logic                fill_ready,
  input  logic [ADDRW-1:0]    fill_addr,
  input  logic [FILLW-1:0]    fill_data,
  input  logic                core_valid,
  output logic                core_ready,
  input  logic                core_rw,
  input  logic [ADDRW-1:0]    core_addr,
  input  logic [PAYLOADW-1:0] core_payload,
  input  logic [TAGW-1:0]     core_tag,
  output logic                core_rsp_valid,
  input  logic                core_rsp_ready,
  output logic [TAGW-1:0]     core_rsp_tag,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                init_done,
  output logic                da_read,
  output logic                da_fill,
  output logic                da_write,
  output logic [ADDRW-1:0]    da_addr,
  output logic [FILLW-1:0]    da_fill_data,
  output logic [PAYLOADW-1:0] da_payload
);

  localparam int SCW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(LINES - 1);
  localparam logic [SCW-1:0] SLIM = SCW'(FAIR_LIMIT);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [ADDRW-1:0]      cnt_q, cnt_d;
  logic [SCW-1:0]        starve_q, starve_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  init_end_q, init_end_d;
  logic                  flush_end_q, flush_end_d;
  logic                  init_done_q, init_done_d;
  logic                  flush_done_q, flush_done_d;
  logic                  rd_q, rd_d, fl_q, fl_d, wr_q, wr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [TAGW-1:0]       tag_q, tag_d;
  logic [ADDRW-1:0]      addr_q, addr_d;
  logic [FILLW-1:0]      fdata_q, fdata_d;
  logic [PAYLOADW-1:0]   payload_q, payload_d;

  logic hold, sweep_tail, run_open, starved, fill_fire, core_fire;

  // The cycle right after a sweep's last line still belongs to the sweep: no grants, no flush.
  assign hold       = rsp_valid_q & ~core_rsp_ready;
  assign sweep_tail = init_end_q | flush_end_q;
  assign run_open   = (state_q == ST_RUN) & ~sweep_tail & ~hold & ~flush_pend_q;
  assign starved    = (starve_q == SLIM);
  assign core_ready = run_open & (~fill_valid | starved);
  assign fill_ready = run_open & ~(core_valid & starved);
  assign fill_fire  = fill_valid & fill_ready;
  assign core_fire  = core_valid & core_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    init_end_d   = 1'b0;
    flush_end_d  = 1'b0;
    init_done_d  = init_done_q | init_end_q;
    flush_done_d = flush_end_q;
    rd_d         = rd_q;
    fl_d         = fl_q;
    wr_d         = wr_q;
    rsp_valid_d  = rsp_valid_q;
    tag_d        = tag_q;
    addr_d       = addr_q;
    fdata_d      = fdata_q;
    payload_d    = payload_q;
    starve_d     = starve_q;

    if (!core_valid || core_fire) begin
      starve_d = '0;
    end else if (fill_fire && !starved) begin
      starve_d = starve_q + SCW'(1);
    end

    case (state_q)
      ST_INIT, ST_FLUSH: begin
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        fl_d        = 1'b1;
        rsp_valid_d = 1'b0;
        addr_d      = cnt_q;
        fdata_d     = '0;
        if (cnt_q == LAST) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_end_d  = (state_q == ST_INIT);
          flush_end_d = (state_q == ST_FLUSH);
        end else begin
          cnt_d = cnt_q + ADDRW'(1);
        end
      end
      default: begin
        if (hold) begin
          if (flush_req) flush_pend_d = 1'b1;
        end else begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          fl_d        = 1'b0;
          rsp_valid_d = 1'b0;
          if (fill_fire) begin
            fl_d    = 1'b1;
            addr_d  = fill_addr;
            fdata_d = fill_data;
          end else if (core_fire) begin
            addr_d    = core_addr;
            payload_d = core_payload;
            if (core_rw) begin
              wr_d = 1'b1;
            end else begin
              rd_d        = 1'b1;
              rsp_valid_d = 1'b1;
              tag_d       = core_tag;
            end
          end
          // A flush colliding with a grant waits one cycle so the granted op issues first.
          if (!sweep_tail && (flush_req || flush_pend_q)) begin
            if (fill_fire || core_fire) begin
              flush_pend_d = 1'b1;
            end else begin
              state_d      = ST_FLUSH;
              cnt_d        = ADDRW'(1);
              fl_d         = 1'b1;
              addr_d       = '0;
              fdata_d      = '0;
              flush_pend_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      starve_q     <= '0;
      flush_pend_q <= 1'b0;
      init_end_q   <= 1'b0;
      flush_end_q  <= 1'b0;
      init_done_q  <= 1'b0;
      flush_done_q <= 1'b0;
      rd_q         <= 1'b0;
      fl_q         <= 1'b0;
      wr_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      tag_q        <= '0;
      addr_q       <= '0;
      fdata_q      <= '0;
      payload_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      flush_pend_q <= flush_pend_d;
      init_end_q   <= init_end_d;
      flush_end_q  <= flush_end_d;
      init_done_q  <= init_done_d;
      flush_done_q <= flush_done_d;
      rd_q         <= rd_d;
      fl_q         <= fl_d;
      wr_q         <= wr_d;
      rsp_valid_q  <= rsp_valid_d;
      tag_q        <= tag_d;
      addr_q       <= addr_d;
      fdata_q      <= fdata_d;
      payload_q    <= payload_d;
    end
  end

  assign core_rsp_valid = rsp_valid_q;
  assign core_rsp_tag   = tag_q;
  assign flush_done     = flush_done_q;
  assign init_done      = init_done_q;
  assign da_read        = rd_q;
  assign da_fill        = fl_q;
  assign da_write       = wr_q;
  assign da_addr        = addr_q;
  assign da_fill_data   = fdata_q;
  assign da_payload     = payload_q;

endmodule

// File: tb/tb_data_access_sched.sv
// tb/tb_data_access_sched.sv - scoreboard bench for data_access_sched
// Sources replay request queues; a monitor pops expected store ops as they issue.
module tb_data_access_sched;

  localparam int LINES    = 8;
  localparam int ADDRW    = 3;
  localparam int FILLW    = 32;
  localparam int PAYLOADW = 16;
  localparam int TAGW     = 8;
  localparam int FAIR     = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                fill_valid, fill_ready;
  logic [ADDRW-1:0]    fill_addr;
  logic [FILLW-1:0]    fill_data;
  logic                core_valid, core_ready, core_rw;
  logic [ADDRW-1:0]    core_addr;
  logic [PAYLOADW-1:0] core_payload;
  logic [TAGW-1:0]     core_tag;
  logic                core_rsp_valid, core_rsp_ready;
  logic [TAGW-1:0]     core_rsp_tag;
  logic                flush_req, flush_done, init_done;
  logic                da_read, da_fill, da_write;
  logic [ADDRW-1:0]    da_addr;
  logic [FILLW-1:0]    da_fill_data;
  logic [PAYLOADW-1:0] da_payload;

  data_access_sched #(
    .LINES(LINES), .ADDRW(ADDRW), .FILLW(FILLW), .PAYLOADW(PAYLOADW),
    .TAGW(TAGW), .FAIR_LIMIT(FAIR)
  ) dut (
    .clk(clk), .reset(reset),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_rw(core_rw), .core_addr(core_addr),
    .core_payload(core_payload), .core_tag(core_tag),
    .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready), .core_rsp_tag(core_rsp_tag),
    .flush_req(flush_req), .flush_done(flush_done), .init_done(init_done),
    .da_read(da_read), .da_fill(da_fill), .da_write(da_write), .da_addr(da_addr),
    .da_fill_data(da_fill_data), .da_payload(da_payload)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  kind;   // 0 fill, 1 write, 2 read
    logic [ADDRW-1:0]    addr;
    logic [FILLW-1:0]    data;
    logic [PAYLOADW-1:0] pl;
    logic [TAGW-1:0]     tag;
  } op_t;

  op_t fq[$];
  op_t cq[$];
  op_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic op_t mk(input int k, input int a, input logic [FILLW-1:0] d,
                             input logic [PAYLOADW-1:0] p, input logic [TAGW-1:0] t);
    op_t o;
    o.kind = k;
    o.addr = a[ADDRW-1:0];
    o.data = d;
    o.pl   = p;
    o.tag  = t;
    return o;
  endfunction

  task automatic push_sweep();
    for (int i = 0; i < LINES; i++) exp_q.push_back(mk(0, i, '0, '0, '0));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((fq.size() + cq.size() + exp_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle", 64'(fq.size() + cq.size() + exp_q.size()), 64'd0);
  endtask

  // Request sources: hold the queue head until the handshake completes.
  initial begin : source
    op_t t;
    bit  f_fire, c_fire;
    fill_valid = 0; fill_addr = '0; fill_data = '0;
    core_valid = 0; core_rw = 0; core_addr = '0; core_payload = '0; core_tag = '0;
    forever begin
      @(negedge clk);
      f_fire = fill_valid && fill_ready;
      c_fire = core_valid && core_ready;
      @(posedge clk);
      #1;
      if (f_fire) t = fq.pop_front();
      if (c_fire) t = cq.pop_front();
      fill_valid = (fq.size() != 0);
      if (fq.size() != 0) begin
        fill_addr = fq[0].addr;
        fill_data = fq[0].data;
      end
      core_valid = (cq.size() != 0);
      if (cq.size() != 0) begin
        core_rw      = (cq[0].kind == 1);
        core_addr    = cq[0].addr;
        core_payload = cq[0].pl;
        core_tag     = cq[0].tag;
      end
    end
  end

  // Monitor: each newly issued op (not a held repeat) must match the next expected op.
  initial begin : monitor
    op_t e;
    bit  prev_hold;
    logic [2:0] ek;
    prev_hold = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_hold = 0;
      end else begin
        if ((da_read || da_write || da_fill) && !prev_hold) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_op", {da_read, da_write, da_fill}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            ek = (e.kind == 0) ? 3'b001 : (e.kind == 1) ? 3'b010 : 3'b100;
            check_eq("op_kind", {da_read, da_write, da_fill}, 64'(ek));
            check_eq("op_addr", 64'(da_addr), 64'(e.addr));
            if (e.kind == 0) check_eq("fill_data", 64'(da_fill_data), 64'(e.data));
            else check_eq("payload", 64'(da_payload), 64'(e.pl));
            check_eq("rsp_valid", 64'(core_rsp_valid), 64'(e.kind == 2));
            if (e.kind == 2) check_eq("rsp_tag", 64'(core_rsp_tag), 64'(e.tag));
          end
        end
        prev_hold = core_rsp_valid && !core_rsp_ready;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    op_t fops[10];
    int  fcount, n, dones;
    bit  found;

    reset = 0; core_rsp_ready = 1; flush_req = 0;
    push_sweep();
    repeat (3) @(negedge clk);
    check_eq("rst_fill", 64'(da_fill), 64'd0);
    check_eq("rst_addr", 64'(da_addr), 64'd0);
    check_eq("rst_init_done", 64'(init_done), 64'd0);
    check_eq("rst_fill_ready", 64'(fill_ready), 64'd0);
    reset = 1;

    // Initial sweep: lines 0..LINES-1, readies low, init_done on the following cycle.
    for (int i = 1; i <= LINES; i++) begin
      @(negedge clk);
      check_eq("init_addr", 64'(da_addr), 64'(i - 1));
      check_eq("init_fill", 64'(da_fill), 64'd1);
      check_eq("init_readies", {fill_ready, core_ready}, 64'd0);
      check_eq("init_done_early", 64'(init_done), 64'd0);
    end
    @(negedge clk);
    check_eq("init_done", 64'(init_done), 64'd1);

    // Write then read of line 3: issued on consecutive cycles.
    cq.push_back(mk(1, 3, '0, 16'h1234, '0));
    cq.push_back(mk(2, 3, '0, 16'hBEEF, 8'h5A));
    exp_q.push_back(mk(1, 3, '0, 16'h1234, '0));
    exp_q.push_back(mk(2, 3, '0, 16'hBEEF, 8'h5A));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (da_write) found = 1;
    end
    check_eq("wr_seen", 64'(found), 64'd1);
    @(negedge clk);
    check_eq("rd_next", {da_read, core_rsp_valid}, 64'd3);
    check_eq("rd_tag", 64'(core_rsp_tag), 64'h5A);
    wait_idle(40);

    // Fairness: both sides valid every cycle -> 4 fills, 1 core, repeating.
    for (int i = 0; i < 10; i++) begin
      fops[i] = mk(0, i % LINES, FILLW'($urandom), '0, '0);
      fq.push_back(fops[i]);
    end
    cq.push_back(mk(1, 1, '0, 16'hA1A1, '0));
    cq.push_back(mk(2, 4, '0, 16'hB2B2, 8'h33));
    fcount = 0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < FAIR; k++) begin
        exp_q.push_back(fops[fcount]);
        fcount++;
      end
      exp_q.push_back(cq[c]);
    end
    while (fcount < 10) begin
      exp_q.push_back(fops[fcount]);
      fcount++;
    end
    wait_idle(80);

    // Held read response: outputs frozen, readies low, then one response and a fill.
    core_rsp_ready = 0;
    cq.push_back(mk(2, 6, '0, 16'h0C0C, 8'h77));
    exp_q.push_back(mk(2, 6, '0, 16'h0C0C, 8'h77));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (da_read) found = 1;
    end
    check_eq("hold_rd_seen", 64'(found), 64'd1);
    fq.push_back(mk(0, 5, 32'hCAFE0005, '0, '0));
    exp_q.push_back(mk(0, 5, 32'hCAFE0005, '0, '0));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("hold_rd", 64'(da_read), 64'd1);
      check_eq("hold_addr", 64'(da_addr), 64'd6);
      check_eq("hold_tag", 64'(core_rsp_tag), 64'h77);
      check_eq("hold_readies", {fill_ready, core_ready}, 64'd0);
    end
    @(posedge clk);
    #1 core_rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check_eq("release_one_rsp", 64'(core_rsp_valid), 64'd0);
    wait_idle(40);

    // flush_req under hold: pending until response taken, then sweep and one flush_done.
    core_rsp_ready = 0;
    cq.push_back(mk(2, 2, '0, 16'h2222, 8'h11));
    exp_q.push_back(mk(2, 2, '0, 16'h2222, 8'h11));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (da_read) found = 1;
    end
    check_eq("fh_rd_seen", 64'(found), 64'd1);
    @(posedge clk);
    #1 flush_req = 1;
    @(posedge clk);
    #1 flush_req = 0;
    @(negedge clk);
    check_eq("fh_no_sweep", {da_fill, da_read}, 64'd1);
    @(posedge clk);
    #1;
    push_sweep();
    core_rsp_ready = 1;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (flush_done) dones++;
    end
    check_eq("flush_done_pulses", 64'(dones), 64'd1);
    wait_idle(20);

    // Reset in the middle of a flush sweep, then a fresh full init sweep.
    @(posedge clk);
    #1 flush_req = 1;
    push_sweep();
    @(posedge clk);
    #1 flush_req = 0;
    @(negedge clk);
    check_eq("flush_line0", {da_fill, 1'b0, da_addr}, 64'h10);
    found = 0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (da_fill && da_addr == 3'd5) found = 1;
    end
    check_eq("line5_seen", 64'(found), 64'd1);
    #1 reset = 0;
    #1;
    check_eq("arst_outs", {da_read, da_fill, da_write, core_rsp_valid, flush_done, init_done}, 64'd0);
    check_eq("arst_addr", 64'(da_addr), 64'd0);
    exp_q.delete();
    push_sweep();
    repeat (2) @(negedge clk);
    reset = 1;
    for (int i = 1; i <= LINES; i++) begin
      @(negedge clk);
      check_eq("reinit_addr", 64'(da_addr), 64'(i - 1));
      check_eq("reinit_done_low", 64'(init_done), 64'd0);
    end
    @(negedge clk);
    check_eq("reinit_done", 64'(init_done), 64'd1);
    wait_idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
